stereo_sensor_emulator: RTL and testbench

//  Transmit side of the camera pixel bus. It generates frame_valid, line_valid and

---
 rtl/stereo_sensor_emulator.sv | 178 +++++++++++++++++
 tb/tb_stereo_sensor_emulator.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_sensor_emulator.sv
// Stereo camera pixel-bus source: each row goes out as a left line, then a right line shifted by 'shift'.
// Latency: frame_valid rises 1 cycle after enable is sampled; outputs are registered.
// Backpressure: none; free-running sensor timing. enable is sampled only in IDLE and at the end of VBLANK.
//
// Ports:
//   clock        pixel clock, rising edge
//   reset        asynchronous, active-high
//   enable       level; high starts a frame / keeps frames streaming
//   pattern_sel  test pattern (0 ramp-x, 1 ramp-y, 2 checker, 3 diagonal), latched at frame start
//   shift        right-line disparity in pixels, latched at frame start
//   frame_valid  high over lead, all lines and their horizontal blanks
//   line_valid   high for H_ACTIVE cycles per transmitted line
//   pixel_data   pixel value, 8'h00 whenever line_valid is low
//   frame_count  completed frames, wraps
module stereo_sensor_emulator #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 16,
    parameter int V_ACTIVE = 480,
    parameter int FV_LEAD  = 4,
    parameter int V_BLANK  = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [5:0]  shift,
    output logic        frame_valid,
    output logic        line_valid,
    output logic [7:0]  pixel_data,
    output logic [15:0] frame_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEAD   = 3'd1;
    localparam logic [2:0] ACTIVE = 3'd2;
    localparam logic [2:0] HBLANK = 3'd3;
    localparam logic [2:0] VBLANK = 3'd4;

    localparam logic [15:0] LEAD_LAST   = 16'(FV_LEAD - 1);
    localparam logic [15:0] HBLANK_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VBLANK_LAST = 16'(V_BLANK - 1);
    localparam logic [10:0] X_LAST      = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST      = 11'(V_ACTIVE - 1);

    logic [2:0]  state, nxt_state;
    logic [15:0] cnt, nxt_cnt;
    logic [10:0] x, nxt_x;
    logic [10:0] y, nxt_y;
    logic        right, nxt_right;
    logic [1:0]  pat, nxt_pat;
    logic [5:0]  shf, nxt_shf;
    logic        fc_inc;
    logic [7:0]  xe;
    logic [7:0]  pix;

    // Next-state logic. Outputs are registered from the next-state values so
    // that pixel_data lines up with line_valid on the same cycle.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_x     = x;
        nxt_y     = y;
        nxt_right = right;
        nxt_pat   = pat;
        nxt_shf   = shf;
        fc_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    nxt_state = LEAD;
                    nxt_cnt   = 16'd0;
                    nxt_x     = 11'd0;
                    nxt_y     = 11'd0;
                    nxt_right = 1'b0;
                    nxt_pat   = pattern_sel;
                    nxt_shf   = shift;
                end
            end
            LEAD: begin
                if (cnt == LEAD_LAST) begin
                    nxt_state = ACTIVE;
                    nxt_x     = 11'd0;
                end else begin
                    nxt_cnt = cnt + 16'd1;
                end
            end
            ACTIVE: begin
                if (x == X_LAST) begin
                    nxt_state = HBLANK;
                    nxt_cnt   = 16'd0;
                end else begin
                    nxt_x = x + 11'd1;
                end
            end
            HBLANK: begin
                if (cnt == HBLANK_LAST) begin
                    if (right && (y == Y_LAST)) begin
                        // Last right line done: frame is complete on this edge.
                        nxt_state = VBLANK;
                        nxt_cnt   = 16'd0;
                        fc_inc    = 1'b1;
                    end else begin
                        nxt_state = ACTIVE;
                        nxt_x     = 11'd0;
                        nxt_right = ~right;
                        if (right) begin
                            nxt_y = y + 11'd1;
                        end
                    end
                end else begin
                    nxt_cnt = cnt + 16'd1;
                end
            end
            VBLANK: begin
                if (cnt == VBLANK_LAST) begin
                    if (enable) begin
                        nxt_state = LEAD;
                        nxt_cnt   = 16'd0;
                        nxt_x     = 11'd0;
                        nxt_y     = 11'd0;
                        nxt_right = 1'b0;
                        nxt_pat   = pattern_sel;
                        nxt_shf   = shift;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else begin
                    nxt_cnt = cnt + 16'd1;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Only the low 8 bits of xe matter, so the sum is kept at 8 bits (mod 256).
    always_comb begin
        xe = nxt_x[7:0] + (nxt_right ? {2'b00, nxt_shf} : 8'h00);
        case (nxt_pat)
            2'd0:    pix = xe;
            2'd1:    pix = nxt_y[7:0];
            2'd2:    pix = (xe[3] ^ nxt_y[3]) ? 8'hFF : 8'h00;
            default: pix = xe + nxt_y[7:0];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            x           <= 11'd0;
            y           <= 11'd0;
            right       <= 1'b0;
            pat         <= 2'd0;
            shf         <= 6'd0;
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            pixel_data  <= 8'h00;
            frame_count <= 16'd0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            x           <= nxt_x;
            y           <= nxt_y;
            right       <= nxt_right;
            pat         <= nxt_pat;
            shf         <= nxt_shf;
            frame_valid <= (nxt_state == LEAD) || (nxt_state == ACTIVE) || (nxt_state == HBLANK);
            line_valid  <= (nxt_state == ACTIVE);
            pixel_data  <= (nxt_state == ACTIVE) ? pix : 8'h00;
            if (fc_inc) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stereo_sensor_emulator.sv
// Bench for the stereo sensor emulator with a small timing configuration.
// Expected pixels are queued when a frame's pattern/shift is driven and popped as lines arrive.
// Frame/line lengths, blank gaps, frame_count and reset behaviour are checked by a negedge monitor.
module tb_stereo_sensor_emulator;

    localparam int HA = 8;
    localparam int HB = 2;
    localparam int VA = 2;
    localparam int FL = 1;
    localparam int VB = 3;
    localparam int FV_HIGH = FL + 2 * VA * (HA + HB);   // 41

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [5:0]  shift = 6'd0;
    logic        frame_valid;
    logic        line_valid;
    logic [7:0]  pixel_data;
    logic [15:0] frame_count;

    stereo_sensor_emulator #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_ACTIVE (VA),
        .FV_LEAD  (FL),
        .V_BLANK  (VB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .shift       (shift),
        .frame_valid (frame_valid),
        .line_valid  (line_valid),
        .pixel_data  (pixel_data),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] exp_q[$];

    int   frames_done = 0;
    int   rises       = 0;
    int   pulses      = 0;
    int   fv_cnt      = 0;
    int   lv_run      = 0;
    int   gap_cnt     = 0;
    int   last_gap    = 0;
    logic fv_prev     = 1'b0;
    logic lv_prev     = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_pix(input int pat, input int shf, input int x,
                                             input int y, input bit rt);
        int xe;
        xe = x + (rt ? shf : 0);
        case (pat)
            0:       return 8'(xe);
            1:       return 8'(y);
            2:       return ((((xe >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
            default: return 8'(xe + y);
        endcase
    endfunction

    task automatic push_frame(input int pat, input int shf);
        for (int yy = 0; yy < VA; yy++)
            for (int s = 0; s < 2; s++)
                for (int xx = 0; xx < HA; xx++)
                    exp_q.push_back(model_pix(pat, shf, xx, yy, s != 0));
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        logic [7:0] e;
        if (reset) begin
            fv_prev     = 1'b0;
            lv_prev     = 1'b0;
            fv_cnt      = 0;
            lv_run      = 0;
            gap_cnt     = 0;
            pulses      = 0;
            frames_done = 0;
        end else begin
            if (line_valid) begin
                check_val("lv_inside_fv", {31'd0, frame_valid}, 32'd1);
                if (exp_q.size() == 0) begin
                    check_val("pix_underflow", exp_q.size(), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("pixel", {24'd0, pixel_data}, {24'd0, e});
                end
            end else begin
                check_val("blank_pix_zero", {24'd0, pixel_data}, 32'd0);
            end

            if (line_valid && !lv_prev) lv_run = 1;
            else if (line_valid) lv_run++;
            if (!line_valid && lv_prev) begin
                check_val("lv_len", lv_run, HA);
                pulses++;
            end

            if (frame_valid && !fv_prev) begin
                last_gap = gap_cnt;
                rises++;
                fv_cnt = 1;
                pulses = 0;
            end else if (frame_valid) begin
                fv_cnt++;
            end

            if (!frame_valid && fv_prev) begin
                check_val("fv_high_len", fv_cnt, FV_HIGH);
                check_val("lv_pulses", pulses, 2 * VA);
                frames_done++;
                check_val("frame_count", {16'd0, frame_count}, frames_done);
                gap_cnt = 1;
            end else if (!frame_valid) begin
                gap_cnt++;
            end

            fv_prev = frame_valid;
            lv_prev = line_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_rises(input int target, input string tag);
        int n = 0;
        while (rises < target && n < 500) begin tick(1); n++; end
        check_val(tag, rises, target);
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (frames_done < target && n < 500) begin tick(1); n++; end
        check_val(tag, frames_done, target);
    endtask

    task automatic wait_pulses(input int target, input string tag);
        int n = 0;
        while (pulses < target && n < 200) begin tick(1); n++; end
        check_val(tag, pulses, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int n;

        // Reset state
        tick(2);
        check_val("rst_fv", {31'd0, frame_valid}, 32'd0);
        check_val("rst_lv", {31'd0, line_valid}, 32'd0);
        check_val("rst_pix", {24'd0, pixel_data}, 32'd0);
        check_val("rst_fc", {16'd0, frame_count}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Single frame from a one-cycle enable pulse; ramp with shift 3
        pattern_sel = 2'd0;
        shift = 6'd3;
        push_frame(0, 3);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        wait_done(1, "t1_done");
        check_val("t1_fc", {16'd0, frame_count}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_val("t1_idle_fv", {31'd0, frame_valid}, 32'd0);
        end
        check_val("t1_q_empty", exp_q.size(), 32'd0);

        // Continuous frames, vertical ramp, shift 0
        pattern_sel = 2'd1;
        shift = 6'd0;
        r0 = rises;
        for (int f = 0; f < 3; f++) push_frame(1, 0);
        enable = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            wait_rises(r0 + f, "t3_rise");
            if (f > 1) check_val("t3_gap", last_gap, VB);
        end
        enable = 1'b0;
        wait_done(4, "t3_done");
        check_val("t3_fc", {16'd0, frame_count}, 32'd4);
        check_val("t3_q_empty", exp_q.size(), 32'd0);

        // Pattern/shift changed mid-frame only affect the next frame
        pattern_sel = 2'd0;
        shift = 6'd3;
        push_frame(0, 3);
        r0 = rises;
        enable = 1'b1;
        wait_rises(r0 + 1, "t4_rise1");
        wait_pulses(1, "t4_mid");
        pattern_sel = 2'd2;
        shift = 6'd5;
        push_frame(2, 5);
        wait_rises(r0 + 2, "t4_rise2");
        check_val("t4_gap", last_gap, VB);
        enable = 1'b0;
        wait_done(6, "t4_done");
        check_val("t4_q_empty", exp_q.size(), 32'd0);

        // enable dropped mid-frame: frame completes, then idle
        pattern_sel = 2'd3;
        shift = 6'd63;
        push_frame(3, 63);
        r0 = rises;
        enable = 1'b1;
        wait_rises(r0 + 1, "t6_rise");
        tick(5);
        enable = 1'b0;
        wait_done(7, "t6_done");
        check_val("t6_fc", {16'd0, frame_count}, 32'd7);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_val("t6_idle_fv", {31'd0, frame_valid}, 32'd0);
        end
        check_val("t6_q_empty", exp_q.size(), 32'd0);

        // Asynchronous reset during the active part of row 1
        pattern_sel = 2'd3;
        shift = 6'd7;
        push_frame(3, 7);
        r0 = rises;
        enable = 1'b1;
        wait_rises(r0 + 1, "t5_rise");
        wait_pulses(2, "t5_row0");
        n = 0;
        while (!line_valid && n < 50) begin tick(1); n++; end
        check_val("t5_in_row1", {31'd0, line_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("t5_rst_fv", {31'd0, frame_valid}, 32'd0);
        check_val("t5_rst_lv", {31'd0, line_valid}, 32'd0);
        check_val("t5_rst_pix", {24'd0, pixel_data}, 32'd0);
        check_val("t5_rst_fc", {16'd0, frame_count}, 32'd0);
        exp_q.delete();
        tick(2);
        pattern_sel = 2'd2;
        shift = 6'd1;
        push_frame(2, 1);
        reset = 1'b0;
        tick(1);
        check_val("t5_lead_fv", {31'd0, frame_valid}, 32'd1);
        check_val("t5_lead_lv", {31'd0, line_valid}, 32'd0);
        tick(1);
        check_val("t5_first_lv", {31'd0, line_valid}, 32'd1);
        enable = 1'b0;
        wait_done(1, "t5_done");
        check_val("t5_fc", {16'd0, frame_count}, 32'd1);
        check_val("t5_q_empty", exp_q.size(), 32'd0);

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
